// File: rtl/hand_tally_if.sv
// Bus between the turn controller / card decoder side and hand_tally_ctrl.
// The master side drives the scan request and the decoded card values; the slave is the sequencer.
interface hand_tally_if #(
  parameter int HAND_MAX = 8
);
  logic                    start;
  logic                    abort;
  logic [2:0]              mode_in;
  logic [4*HAND_MAX-1:0]   hand_cards;
  logic [3:0]              hand_count;
  logic [2:0]              dec_buy;
  logic [2:0]              dec_action;
  logic [2:0]              dec_draw;
  logic [4:0]              dec_gold;
  logic [3:0]              card_stream;
  logic [2:0]              mode_out;
  logic                    busy;
  logic                    done;
  logic [3:0]              card_idx;
  logic [5:0]              tot_buy;
  logic [5:0]              tot_action;
  logic [5:0]              tot_draw;
  logic [7:0]              tot_gold;

  modport master (
    output start, abort, mode_in, hand_cards, hand_count,
           dec_buy, dec_action, dec_draw, dec_gold,
    input  card_stream, mode_out, busy, done, card_idx,
           tot_buy, tot_action, tot_draw, tot_gold
  );

  modport slave (
    input  start, abort, mode_in, hand_cards, hand_count,
           dec_buy, dec_action, dec_draw, dec_gold,
    output card_stream, mode_out, busy, done, card_idx,
           tot_buy, tot_action, tot_draw, tot_gold
  );
endinterface

// File: rtl/hand_tally_ctrl.sv
// Walks a latched hand/shop row onto the card decoder and accumulates saturating turn totals.
// Optional macro SKIP_EMPTY_EN: empty slots (address 0) are skipped in one cycle without decoding.
//
// state | meaning
// IDLE  | waiting for start; totals and mode_out hold from the last scan
// ISSUE | present slot[card_idx] on card_stream
// WAIT  | let the card ROM read settle for ROM_LAT cycles
// ACCUM | add decoded values into the totals, advance or finish
// DONE  | one-cycle done pulse
module hand_tally_ctrl #(
  parameter int HAND_MAX = 8,
  parameter int ROM_LAT  = 1
) (
  input logic   clk,
  input logic   reset,
  hand_tally_if.slave bus
);
  localparam int IDX_W = (HAND_MAX > 1) ? $clog2(HAND_MAX) : 1;
  localparam int LAT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam logic [3:0]       CNT_MAX  = 4'(HAND_MAX);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(ROM_LAT - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACCUM, DONE} state_t;

  state_t           state;
  logic [3:0]       slots [HAND_MAX];
  logic [3:0]       count_lat;
  logic [LAT_W-1:0] wait_cnt;
  logic [3:0]       card_stream_q;
  logic [2:0]       mode_q;
  logic             busy_q;
  logic             done_q;
  logic [3:0]       card_idx_q;
  logic [5:0]       tot_buy_q;
  logic [5:0]       tot_action_q;
  logic [5:0]       tot_draw_q;
  logic [7:0]       tot_gold_q;

  logic [3:0] count_clamped;
  logic [3:0] cur_slot;
  logic       last_card;

  assign count_clamped = (bus.hand_count > CNT_MAX) ? CNT_MAX : bus.hand_count;
  assign cur_slot      = slots[card_idx_q[IDX_W-1:0]];
  assign last_card     = (card_idx_q == count_lat - 4'd1);

  function automatic logic [5:0] sat6(input logic [5:0] a, input logic [2:0] b);
    logic [6:0] s;
    s = {1'b0, a} + {4'b0, b};
    return s[6] ? 6'h3f : s[5:0];
  endfunction

  function automatic logic [7:0] sat8(input logic [7:0] a, input logic [4:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {4'b0, b};
    return s[8] ? 8'hff : s[7:0];
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      for (int k = 0; k < HAND_MAX; k++) slots[k] <= '0;
      count_lat     <= '0;
      wait_cnt      <= '0;
      card_stream_q <= '0;
      mode_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      card_idx_q    <= '0;
      tot_buy_q     <= '0;
      tot_action_q  <= '0;
      tot_draw_q    <= '0;
      tot_gold_q    <= '0;
    end else if (bus.abort) begin
      // Partial totals are kept; only the sequencing is dropped.
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            mode_q    <= bus.mode_in;
            for (int k = 0; k < HAND_MAX; k++) slots[k] <= bus.hand_cards[4*k +: 4];
            count_lat    <= count_clamped;
            card_idx_q   <= '0;
            tot_buy_q    <= '0;
            tot_action_q <= '0;
            tot_draw_q   <= '0;
            tot_gold_q   <= '0;
            if (count_clamped != 4'd0) begin
              state  <= ISSUE;
              busy_q <= 1'b1;
            end else begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
`ifdef SKIP_EMPTY_EN
          if (cur_slot == 4'h0) begin
            if (last_card) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              card_idx_q <= card_idx_q + 4'd1;
            end
          end else begin
            card_stream_q <= cur_slot;
            wait_cnt      <= LAT_LOAD;
            state         <= WAIT;
          end
`else
          card_stream_q <= cur_slot;
          wait_cnt      <= LAT_LOAD;
          state         <= WAIT;
`endif
        end
        WAIT: begin
          if (wait_cnt == '0) state <= ACCUM;
          else                wait_cnt <= wait_cnt - 1'b1;
        end
        ACCUM: begin
          tot_buy_q    <= sat6(tot_buy_q, bus.dec_buy);
          tot_action_q <= sat6(tot_action_q, bus.dec_action);
          tot_draw_q   <= sat6(tot_draw_q, bus.dec_draw);
          tot_gold_q   <= sat8(tot_gold_q, bus.dec_gold);
          if (last_card) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            card_idx_q <= card_idx_q + 4'd1;
            state      <= ISSUE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.card_stream = card_stream_q;
  assign bus.mode_out    = mode_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.card_idx    = card_idx_q;
  assign bus.tot_buy     = tot_buy_q;
  assign bus.tot_action  = tot_action_q;
  assign bus.tot_draw    = tot_draw_q;
  assign bus.tot_gold    = tot_gold_q;
endmodule

// File: tb/tb_hand_tally_ctrl.sv
// Self-checking bench for hand_tally_ctrl: table vectors, corner sequences and random scans
// against a per-cycle timeline model built from the card latency rules.
module tb_hand_tally_ctrl;
  localparam int HM = 8;
  localparam int RL = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hand_tally_if #(.HAND_MAX(HM)) b ();
  hand_tally_ctrl #(.HAND_MAX(HM), .ROM_LAT(RL)) u_dut (.clk(clk), .reset(reset), .bus(b));

  hand_tally_if #(.HAND_MAX(9)) b9 ();
  hand_tally_ctrl #(.HAND_MAX(9), .ROM_LAT(RL)) u_dut9 (.clk(clk), .reset(reset), .bus(b9));

  typedef struct packed {
    logic [2:0] buy;
    logic [2:0] action;
    logic [2:0] draw;
    logic [4:0] gold;
  } rom_t;

  function automatic rom_t rom(input logic [3:0] a);
    rom_t r;
    r = '0;
    case (a)
      4'd0: r.action = 3'd1;
      4'd1: r.gold = 5'd1;
      4'd2: r.gold = 5'd2;
      4'd3: r.gold = 5'd3;
      4'd4: begin r.buy = 3'd1; r.action = 3'd2; r.draw = 3'd2; end
      4'd5: r.gold = 5'd31;
      default: begin
        r.buy    = a[2:0];
        r.action = a[3:1];
        r.draw   = {1'b0, a[1:0]};
        r.gold   = {1'b0, a} + 5'd7;
      end
    endcase
    return r;
  endfunction

  // Card ROM with one clock of read latency for each instance
  always @(posedge clk) {b.dec_buy, b.dec_action, b.dec_draw, b.dec_gold} <= rom(b.card_stream);
  always @(posedge clk) {b9.dec_buy, b9.dec_action, b9.dec_draw, b9.dec_gold} <= rom(b9.card_stream);

  int nerr = 0;
  int nchk = 0;
  logic [3:0] model_stream;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Start a scan from IDLE and check every cycle against the model timeline.
  // poke holds start high (with junk inputs) through the scan and the DONE cycle.
  task automatic run_scan(input logic [31:0] cards, input logic [3:0] cnt,
                          input logic [2:0] mode, input bit poke, output int obs_done);
    logic [3:0] es [64];
    bit eb [64];
    bit ed [64];
    logic [3:0] cur, a;
    logic [31:0] cv;
    rom_t r;
    int n, t, sb, sa, sd, sg;
    n = (int'(cnt) > HM) ? HM : int'(cnt);
    cur = model_stream;
    cv = cards;
    t = 0; sb = 0; sa = 0; sd = 0; sg = 0;
    for (int k = 0; k < n; k++) begin
      a = cv[4*k +: 4];
`ifdef SKIP_EMPTY_EN
      if (a == 4'h0) begin
        es[t] = cur; eb[t] = 1'b1; ed[t] = 1'b0;
        t++;
        continue;
      end
`endif
      es[t] = cur; eb[t] = 1'b1; ed[t] = 1'b0;
      cur = a;
      for (int j = 1; j <= 1 + RL; j++) begin
        es[t+j] = cur; eb[t+j] = 1'b1; ed[t+j] = 1'b0;
      end
      t += 2 + RL;
      r = rom(a);
      sb += int'(r.buy); sa += int'(r.action); sd += int'(r.draw); sg += int'(r.gold);
    end
    if (sb > 63) sb = 63;
    if (sa > 63) sa = 63;
    if (sd > 63) sd = 63;
    if (sg > 255) sg = 255;
    es[t] = cur;   eb[t] = 1'b0;   ed[t] = 1'b1;
    es[t+1] = cur; eb[t+1] = 1'b0; ed[t+1] = 1'b0;
    model_stream = cur;

    obs_done = -1;
    b.hand_cards = cards;
    b.hand_count = cnt;
    b.mode_in = mode;
    b.start = 1'b1;
    @(posedge clk);
    #1;
    b.hand_cards = $urandom;
    b.hand_count = 4'($urandom_range(0, 15));
    b.mode_in = 3'($urandom_range(0, 7));
    b.start = poke;
    for (int c = 0; c <= t + 1; c++) begin
      @(negedge clk);
      if (b.done && obs_done < 0) obs_done = c;
      chk("stream", int'(b.card_stream), int'(es[c]));
      chk("busy", int'(b.busy), int'(eb[c]));
      chk("done", int'(b.done), int'(ed[c]));
      if (c == t) begin
        chk("tot_buy", int'(b.tot_buy), sb);
        chk("tot_action", int'(b.tot_action), sa);
        chk("tot_draw", int'(b.tot_draw), sd);
        chk("tot_gold", int'(b.tot_gold), sg);
        chk("mode_out", int'(b.mode_out), int'(mode));
        chk("card_idx", int'(b.card_idx), (n == 0) ? 0 : n - 1);
      end
      if (c == t + 1) chk("tot_gold_hold", int'(b.tot_gold), sg);
      b.start = (poke && c < t + 1) ? 1'b1 : 1'b0;
    end
    b.start = 1'b0;
  endtask

  typedef struct {
    logic [31:0] cards;
    logic [3:0]  cnt;
    logic [2:0]  mode;
    int buy, action, draw, gold, cycles;
  } vec_t;

  vec_t vt [6];
  int od, seen, got_i;

  initial begin
    vt[0] = '{32'h0000_0321, 4'd3,  3'd1, 0, 0,  0,  6,   9};
    vt[1] = '{32'h0000_0321, 4'd0,  3'd2, 0, 0,  0,  0,   0};
    vt[2] = '{32'h1111_1111, 4'd12, 3'd3, 0, 0,  0,  8,   24};
    vt[3] = '{32'h4444_4444, 4'd8,  3'd4, 8, 16, 16, 0,   24};
    vt[4] = '{32'h5555_5555, 4'd8,  3'd5, 0, 0,  0,  248, 24};
`ifdef SKIP_EMPTY_EN
    vt[5] = '{32'h0000_0201, 4'd4,  3'd6, 0, 0,  0,  3,   8};
`else
    vt[5] = '{32'h0000_0201, 4'd4,  3'd6, 0, 2,  0,  3,   12};
`endif

    reset = 1'b1;
    b.start = 0; b.abort = 0; b.mode_in = 0; b.hand_cards = 0; b.hand_count = 0;
    b9.start = 0; b9.abort = 0; b9.mode_in = 0; b9.hand_cards = 0; b9.hand_count = 0;
    model_stream = 4'h0;
    repeat (2) @(negedge clk);
    chk("rst_stream", int'(b.card_stream), 0);
    chk("rst_mode", int'(b.mode_out), 0);
    chk("rst_busy", int'(b.busy), 0);
    chk("rst_done", int'(b.done), 0);
    chk("rst_idx", int'(b.card_idx), 0);
    chk("rst_gold", int'(b.tot_gold), 0);
    reset = 1'b0;

    // Reset during ACCUM of the third card
    b.hand_cards = 32'h0000_0123; b.hand_count = 4'd3; b.mode_in = 3'd5; b.start = 1'b1;
    @(posedge clk);
    #1 b.start = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_rst_busy", int'(b.busy), 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_stream", int'(b.card_stream), 0);
    chk("mid_rst_mode", int'(b.mode_out), 0);
    chk("mid_rst_busy", int'(b.busy), 0);
    chk("mid_rst_done", int'(b.done), 0);
    chk("mid_rst_idx", int'(b.card_idx), 0);
    chk("mid_rst_gold", int'(b.tot_gold), 0);
    chk("mid_rst_buy", int'(b.tot_buy), 0);
    @(negedge clk);
    reset = 1'b0;
    model_stream = 4'h0;

    for (int i = 0; i < 6; i++) begin
      run_scan(vt[i].cards, vt[i].cnt, vt[i].mode, 1'b0, od);
      chk("vec_cycles", od, vt[i].cycles);
      chk("vec_buy", int'(b.tot_buy), vt[i].buy);
      chk("vec_action", int'(b.tot_action), vt[i].action);
      chk("vec_draw", int'(b.tot_draw), vt[i].draw);
      chk("vec_gold", int'(b.tot_gold), vt[i].gold);
    end

    // Start repeatedly during a scan and in its DONE cycle
    run_scan(32'h0000_0321, 4'd3, 3'd2, 1'b1, od);
    chk("poke_cycles", od, 9);
    run_scan(32'h0000_0000, 4'd0, 3'd1, 1'b1, od);
    chk("poke_zero_cycles", od, 0);

    // Abort during WAIT of the second card
    b.hand_cards = 32'h0000_0132; b.hand_count = 4'd3; b.mode_in = 3'd1; b.start = 1'b1;
    @(posedge clk);
    #1 b.start = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_pre_stream", int'(b.card_stream), 3);
    b.abort = 1'b1;
    @(negedge clk);
    b.abort = 1'b0;
    chk("abort_busy", int'(b.busy), 0);
    chk("abort_done", int'(b.done), 0);
    chk("abort_gold", int'(b.tot_gold), 2);
    chk("abort_stream", int'(b.card_stream), 3);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (b.done) seen = 1;
    end
    chk("abort_no_done", seen, 0);
    model_stream = 4'h3;

    // start and abort together in IDLE
    b.hand_cards = 32'h0000_0011; b.hand_count = 4'd2; b.start = 1'b1; b.abort = 1'b1;
    @(negedge clk);
    b.start = 1'b0; b.abort = 1'b0;
    chk("sa_busy", int'(b.busy), 0);
    chk("sa_done", int'(b.done), 0);
    @(negedge clk);
    chk("sa_done2", int'(b.done), 0);
    chk("sa_gold", int'(b.tot_gold), 2);

    for (int r = 0; r < 25; r++) begin
      run_scan($urandom, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
               bit'($urandom_range(0, 1)), od);
    end

    // Gold saturation needs nine cards: HAND_MAX=9 instance
    b9.hand_cards = 36'h5_5555_5555; b9.hand_count = 4'd9; b9.start = 1'b1;
    @(posedge clk);
    #1 b9.start = 1'b0;
    got_i = -1;
    for (int i = 0; i < 60 && got_i < 0; i++) begin
      @(negedge clk);
      if (b9.done) got_i = i;
    end
    chk("sat_cycles", got_i, 27);
    chk("sat_gold", int'(b9.tot_gold), 255);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/hand_tally_ctrl.md
Name: hand_tally_ctrl

Overview:
- Sequencer in front of the card decoder. On `start`, walks a packed list of card addresses (hand or shop row) onto the decoder's `card_stream`, one card at a time.
- Waits out the card ROM read latency, then samples the decoded buy/action/draw/gold values and accumulates saturating totals for the turn.
- Sits between the game/turn controller and the decoder. Owns `card_stream` and the decoder `mode` for the duration of a scan.

Parameters:
- HAND_MAX, 8, maximum number of card slots in `hand_cards`.
- ROM_LAT, 1, card ROM read latency in clocks (≥1).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin scan; sampled only in IDLE
- abort  in  1  terminate scan; return to IDLE next edge
- mode_in  in  3  decoder mode, latched at start
- hand_cards  in  4*HAND_MAX  packed card addresses; slot k = bits [4k+3:4k]; latched at start
- hand_count  in  4  number of valid slots; latched at start
- dec_buy  in  3  decoder buy value
- dec_action  in  3  decoder action value
- dec_draw  in  3  decoder draw value
- dec_gold  in  5  decoder gold value (VP in ENDGAME mode)
- card_stream  out  4  address to decoder
- mode_out  out  3  mode to decoder
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse; totals final
- card_idx  out  4  slot currently presented
- tot_buy  out  6  accumulated buy
- tot_action  out  6  accumulated action
- tot_draw  out  6  accumulated draw
- tot_gold  out  8  accumulated gold/VP

Behaviour:
- Reset (async, active-high) forces:
  - state = IDLE
  - `card_stream` = 0, `mode_out` = 0, `card_idx` = 0
  - `busy` = 0, `done` = 0
  - all totals = 0
- Reset mid-scan discards the scan.
- States: IDLE, ISSUE, WAIT, ACCUM, DONE.
- IDLE:
  - On `start`: latch `mode_in`, `hand_cards` and count. Count is clamped to HAND_MAX if `hand_count` > HAND_MAX.
  - Clear totals and `card_idx`.
  - Go to ISSUE if count > 0, else go to DONE.
  - Totals from the previous scan hold until the next `start`.
- ISSUE: drive `card_stream` = slot[`card_idx`]; go to WAIT.
- WAIT:
  - Hold `card_stream` for ROM_LAT cycles (internal counter), then go to ACCUM.
- ACCUM:
  - Add the `dec_*` inputs into the totals.
  - Each total saturates at its all-ones value (63 or 255); no wrap.
  - If `card_idx` == count-1, go to DONE; else increment `card_idx` and go to ISSUE.
- DONE: `done` = 1 for exactly one cycle; go to IDLE. `busy` = 0 in DONE and IDLE.
- `busy` = 1 in ISSUE, WAIT and ACCUM.
- `card_stream` and `mode_out` stay stable from ISSUE through ACCUM of each card.
- `mode_out` holds its latched value in DONE and IDLE until the next `start`.
- Latency with ROM_LAT=1:
  - 3 clocks per card.
  - `start` sampled at edge E0 → `done` high in the cycle after edge E(3N). Generally (2+ROM_LAT)·N.
  - N=0: `done` high in the cycle after E0.
- `start` while not in IDLE is ignored.
- `start` in the DONE cycle is ignored.
- `abort`:
  - Highest priority after reset; from any non-IDLE state go to IDLE at the next edge.
  - No `done` pulse; totals frozen at their partial values.
  - `start` and `abort` together in IDLE: `abort` wins, no scan.
- Input changes to `hand_cards`/`hand_count` during a scan have no effect.

Optional Feature:
- Macro: SKIP_EMPTY_EN.
- Defined:
  - In ISSUE, a slot whose address is 4'h0 (empty card) is not presented and not accumulated.
  - `card_idx` advances (or DONE if last) in 1 cycle, no WAIT/ACCUM.
  - `card_stream` keeps its previous value during a skip.
- Undefined: every slot takes the full 2+ROM_LAT cycles and address 0 is decoded like any other.

Test Plan:
- Bench ROM model: addr1 gold=1, addr2 gold=2, addr3 gold=3, addr4 buy=1 action=2 draw=2.
- Reset mid-ACCUM of a 3-card scan → all outputs 0, IDLE; a new `start` then works normally.
- `hand_cards` = {3,2,1}, count=3, ROM_LAT=1, `start` at E0:
  - `card_stream` sequence 1,2,3.
  - `tot_gold` = 6, `tot_buy` = 0.
  - `done` high in the cycle after E9.
  - `busy` low after.
- count=0 `start` → `done` in the cycle after E0, totals 0, `card_stream` unchanged. count=12 with HAND_MAX=8 → exactly 8 cards scanned.
- 8× addr4 → `tot_buy` = 8, `tot_action` = 16, `tot_draw` = 16. Saturation: ROM model gold=31 for addr5; 9× addr5 → `tot_gold` = 255, not 279 mod 256.
- `abort` during WAIT of card 2 → IDLE next edge, no `done`, `tot_gold` = value after card 1. `start` during a busy scan → ignored, scan unchanged.
- SKIP_EMPTY_EN: `hand_cards` = {0,2,0,1}, count=4 → `tot_gold` = 3, `done` after 1+3+1+3 = 8 cycles. Without the macro: 12 cycles, addr0 decoded.
